// File: rtl/mom_decap_seq.sv
// Sequenced enable of NSEG MOM/decap segments, one step per dwell, to bound rail inrush/droop.
// Optional status outputs (seg_cnt, settled) are enabled by defining MOM_DECAP_SEQ_STATUS_EN.
module mom_decap_seq #(
    parameter int unsigned NSEG    = 8,
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned IDX_W   = $clog2(NSEG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_en,
    input  logic [NSEG-1:0]    seg_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NSEG-1:0]    seg_en,
    output logic               busy,
    output logic               done
`ifdef MOM_DECAP_SEQ_STATUS_EN
    ,
    output logic [$clog2(NSEG+1)-1:0] seg_cnt,
    output logic                      settled
`endif
);

    typedef enum logic [1:0] {StIdleOff, StRampUp, StIdleOn, StRampDown} state_e;

    state_e             state_q, state_d;
    logic [NSEG-1:0]    act_mask_q, act_mask_d;
    logic [NSEG-1:0]    seg_en_q, seg_en_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NSEG-1:0]    up_cand;
    logic [IDX_W-1:0]   lo_idx, hi_idx;
    logic               up_avail, dn_avail, step;
    logic [DWELL_W-1:0] dwell_ld;

    // lo_idx: next segment to enable; hi_idx: highest segment currently on
    always_comb begin
        up_cand = act_mask_q & ~seg_en_q;
        lo_idx  = '0;
        hi_idx  = '0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (up_cand[i]) lo_idx = IDX_W'(i);
        end
        for (int i = 0; i < NSEG; i++) begin
            if (seg_en_q[i]) hi_idx = IDX_W'(i);
        end
        up_avail = |up_cand;
        dn_avail = |seg_en_q;
        step     = (cnt_q == '0);
        dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end

    always_comb begin
        state_d    = state_q;
        act_mask_d = act_mask_q;
        seg_en_d   = seg_en_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdleOff: begin
                if (req_en) begin
                    act_mask_d = seg_mask;
                    cnt_d      = '0;
                    if (seg_mask == '0) begin
                        state_d = StIdleOn;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRampUp;
                    end
                end
            end
            StIdleOn: begin
                if (!req_en) begin
                    state_d = StRampDown;
                    cnt_d   = '0;
                end
            end
            StRampUp: begin
                if (!step) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!req_en) begin
                    // Reversal takes effect as the first ramp-down step
                    state_d = StRampDown;
                    if (dn_avail) seg_en_d[hi_idx] = 1'b0;
                    cnt_d = dwell_ld;
                end else if (up_avail) begin
                    seg_en_d[lo_idx] = 1'b1;
                    cnt_d            = dwell_ld;
                end else begin
                    state_d = StIdleOn;
                    done_d  = 1'b1;
                end
            end
            StRampDown: begin
                if (!step) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (req_en) begin
                    state_d = StRampUp;
                    if (up_avail) seg_en_d[lo_idx] = 1'b1;
                    cnt_d = dwell_ld;
                end else if (dn_avail) begin
                    seg_en_d[hi_idx] = 1'b0;
                    cnt_d            = dwell_ld;
                end else begin
                    state_d = StIdleOff;
                    done_d  = 1'b1;
                end
            end
        endcase
        busy_d = (state_d == StRampUp) || (state_d == StRampDown);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdleOff;
            act_mask_q <= '0;
            seg_en_q   <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_mask_q <= act_mask_d;
            seg_en_q   <= seg_en_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign seg_en = seg_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef MOM_DECAP_SEQ_STATUS_EN
    logic [$clog2(NSEG+1)-1:0] seg_cnt_q, seg_cnt_d;
    logic                      settled_q, settled_d;

    always_comb begin
        seg_cnt_d = '0;
        for (int i = 0; i < NSEG; i++) begin
            seg_cnt_d = seg_cnt_d + {{($clog2(NSEG+1)-1){1'b0}}, seg_en_d[i]};
        end
        settled_d = (state_d == StIdleOn) || (state_d == StIdleOff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_cnt_q <= '0;
            settled_q <= 1'b1;
        end else begin
            seg_cnt_q <= seg_cnt_d;
            settled_q <= settled_d;
        end
    end

    assign seg_cnt = seg_cnt_q;
    assign settled = settled_q;
`else
    // Status outputs absent in this build.
`endif

endmodule
